// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each owner may hold the grant for up to w_eff
// consecutive cycles while others wait, with zero-bubble hand-over.
module wrr_arbiter #(
  parameter  int N   = 4,
  parameter  int WW  = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N-1:0]      req,
  input  logic [N*WW-1:0]   weight,
  output logic [N-1:0]      gnt,
  output logic [IDW-1:0]    gnt_id,
  output logic              gnt_valid
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [WW-1:0]   credit_q, credit_d;
  logic [IDW-1:0]  last_owner_q, last_owner_d;

  logic            hi_any, lo_any;
  logic [IDW-1:0]  hi_idx, lo_idx, win;
  logic [N-1:0]    win_onehot;
  logic            owner_req, others, release_grant, credit_last;

  // Weight field k, with zero promoted to one.
  function automatic logic [WW-1:0] weff(input logic [IDW-1:0] k,
                                         input logic [N*WW-1:0] w);
    logic [WW-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) begin
      if (k == IDW'(i)) f = w[i*WW +: WW];
    end
    return (f == '0) ? WW'(1) : f;
  endfunction

  // Circular scan starting just after last_owner: prefer the lowest requester
  // above last_owner, otherwise wrap to the lowest at or below it.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(last_owner_q)) begin
          hi_any = 1'b1;
          hi_idx = IDW'(i);
        end else begin
          lo_any = 1'b1;
          lo_idx = IDW'(i);
        end
      end
    end
    win        = hi_any ? hi_idx : lo_idx;
    win_onehot = '0;
    win_onehot[win] = 1'b1;
  end

  assign owner_req     = |(req & gnt_q);
  assign others        = |(req & ~gnt_q);
  assign credit_last   = (credit_q == WW'(1));
  assign release_grant = !owner_req || (credit_last && others);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    credit_d     = credit_q;
    last_owner_d = last_owner_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d      = S_GRANT;
          gnt_d        = win_onehot;
          gnt_id_d     = win;
          credit_d     = weff(win, weight);
          last_owner_d = win;
        end
      end
      S_GRANT: begin
        if (release_grant) begin
          if (req == '0) begin
            state_d = S_IDLE;
            gnt_d   = '0;
          end else begin
            // last_owner equals the current owner here, so the scan visits it last.
            gnt_d        = win_onehot;
            gnt_id_d     = win;
            credit_d     = weff(win, weight);
            last_owner_d = win;
          end
        end else if (credit_last) begin
          credit_d = weff(gnt_id_q, weight);
        end else begin
          credit_d = credit_q - WW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      credit_q     <= '0;
      last_owner_q <= IDW'(N - 1);
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      credit_q     <= credit_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed and randomized checks of wrr_arbiter against a tenure-count model
// of the arbitration rules.
module tb_wrr_arbiter;
  localparam int N   = 4;
  localparam int WW  = 4;
  localparam int IDW = $clog2(N);

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who owns the grant, how many cycles of tenure remain, last owner.
  int m_owner, m_left, m_last;

  wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .weight(weight),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int weff_m(input int i);
    int w;
    w = int'((weight >> (i * WW)) & ((1 << WW) - 1));
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_last  = N - 1;
  endtask

  task automatic model_pick();
    bit found = 0;
    int k = 0;
    for (int d = 1; d <= N; d++) begin
      if (!found && req[(m_last + d) % N]) begin
        found = 1;
        k = (m_last + d) % N;
      end
    end
    m_owner = k;
    m_left  = weff_m(k);
    m_last  = k;
  endtask

  task automatic model_edge();
    bit others;
    if (m_owner < 0) begin
      if (req != 0) model_pick();
    end else begin
      others = (req & ~(N'(1) << m_owner)) != 0;
      if (!req[m_owner] || (m_left == 1 && others)) begin
        if (req == 0) m_owner = -1;
        else model_pick();
      end else if (m_left == 1) begin
        m_left = weff_m(m_owner);
      end else begin
        m_left--;
      end
    end
  endtask

  function automatic logic [N-1:0] m_gnt();
    return (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endfunction

  // One clock: model decides from the inputs seen at the edge, DUT is sampled 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt", 32'(gnt), 32'(m_gnt()));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    if (m_owner >= 0) check("gnt_id", 32'(gnt_id), 32'(m_owner));
  endtask

  logic [N-1:0] hist [30];
  int cnt [N];
  int zero_cnt;
  int hold;
  logic [N-1:0] exp_seq [9];

  initial begin
    model_reset();
    rstn   = 1'b0;
    req    = 4'hF;
    weight = 16'h1111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_id", 32'(gnt_id), 32'h0);
    rstn = 1'b1;
    step();
    check("first_grant", 32'(gnt), 32'h1);

    // Lone requester with reloading credit.
    req = 4'b0100;
    weight = 16'h0311;
    for (int i = 0; i < 10; i++) begin
      step();
      check("lone", 32'(gnt), 32'h4);
    end
    req = 4'b0000;
    step();
    check("lone_drop", 32'(gnt), 32'h0);
    check("lone_drop_v", 32'(gnt_valid), 32'h0);

    // Weighted fairness, weights {1,2,3,4}.
    req = 4'hF;
    weight = 16'h4321;
    for (int i = 0; i < 30; i++) begin
      step();
      hist[i] = gnt;
    end
    for (int i = 0; i < N; i++) cnt[i] = 0;
    zero_cnt = 0;
    for (int i = 10; i < 20; i++) begin
      if (hist[i] == 0) zero_cnt++;
      for (int b = 0; b < N; b++) if (hist[i][b]) cnt[b]++;
    end
    for (int b = 0; b < N; b++) check("fair_count", 32'(cnt[b]), 32'(b + 1));
    check("fair_no_bubble", 32'(zero_cnt), 32'h0);
    for (int i = 0; i < 20; i++) check("fair_period", 32'(hist[i + 10]), 32'(hist[i]));

    // Zero-bubble hand-over.
    req = 4'b0000;
    step();
    weight = 16'h1118;
    req = 4'b0001;
    step();
    check("zb_own0", 32'(gnt), 32'h1);
    req = 4'b0011;
    step();
    step();
    check("zb_hold", 32'(gnt), 32'h1);
    req = 4'b0010;
    step();
    check("zb_handover", 32'(gnt), 32'h2);
    check("zb_valid", 32'(gnt_valid), 32'h1);

    // Weight zero acts as one; live weight change applies at the next load.
    req = 4'b0000;
    step();
    weight = 16'h1102;
    req = 4'b0011;
    exp_seq = '{4'h1, 4'h1, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2};
    for (int i = 0; i < 9; i++) begin
      step();
      check("wlive_seq", 32'(gnt), 32'(exp_seq[i]));
      if (i == 0) weight = 16'h1105;
    end

    // Asynchronous reset mid-grant.
    req = 4'b1000;
    step();
    check("ar_pre", 32'(gnt), 32'h8);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_gnt", 32'(gnt), 32'h0);
    check("ar_valid", 32'(gnt_valid), 32'h0);
    model_reset();
    #1;
    rstn = 1'b1;
    req = 4'b1010;
    step();
    check("ar_first", 32'(gnt), 32'h2);

    // Randomized traffic and weights.
    hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        req  = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 5);
      end
      hold--;
      if ($urandom_range(0, 9) == 0) weight = 16'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
